// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcode/state types and helpers for the ALU op sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int ALU_OP_COUNT = 12;

  typedef enum logic [3:0] {
    ALU_OP_ADD = 4'd0,
    ALU_OP_SUB = 4'd1,
    ALU_OP_MUL = 4'd2,
    ALU_OP_DIV = 4'd3,
    ALU_OP_SHR = 4'd4,
    ALU_OP_SHL = 4'd5,
    ALU_OP_ROR = 4'd6,
    ALU_OP_ROL = 4'd7,
    ALU_OP_AND = 4'd8,
    ALU_OP_OR  = 4'd9,
    ALU_OP_NEG = 4'd10,
    ALU_OP_NOT = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Binary opcode to one-hot ALU control, settle latency, legality.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic [3:0]              i_op,
  output logic [ALU_OP_COUNT-1:0] o_ctrl,
  output logic [CNT_W-1:0]        o_lat,
  output logic                    o_legal
);

  always_comb begin
    o_legal = (i_op < 4'(ALU_OP_COUNT));
    o_ctrl  = '0;
    if (o_legal) begin
      o_ctrl = {{(ALU_OP_COUNT-1){1'b0}}, 1'b1} << i_op;
    end
    case (i_op)
      ALU_OP_MUL: o_lat = CNT_W'(MUL_LAT);
      ALU_OP_DIV: o_lat = CNT_W'(DIV_LAT);
      default:    o_lat = CNT_W'(1);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues one op to the combinational ALU, holds it for the
//               op latency, captures Z low/high into a valid/ready response.
//               Optional macro ALU_SEQ_DIV0_TRAP_EN traps DIV by zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_op,
  input  logic [31:0]             req_a,
  input  logic [31:0]             req_b,
  output logic [ALU_OP_COUNT-1:0] alu_ctrl,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  input  logic [31:0]             alu_zlow,
  input  logic [31:0]             alu_zhigh,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_zlow,
  output logic [31:0]             rsp_zhigh,
  output logic                    rsp_err
);

  localparam int CNT_W = $clog2(maxOf(MUL_LAT, DIV_LAT) + 1);

  seq_state_e              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ALU_OP_COUNT-1:0] w_ctrl;
  logic [CNT_W-1:0]        w_lat;
  logic                    w_legal;
  logic                    w_trap;
  logic                    w_go;

  alu_op_decode #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_decode (
    .i_op    (req_op),
    .o_ctrl  (w_ctrl),
    .o_lat   (w_lat),
    .o_legal (w_legal)
  );

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign w_trap = (req_op == ALU_OP_DIV) && (req_b == 32'd0);
`else
  assign w_trap = 1'b0;
`endif

  assign w_go = w_legal && !w_trap;

  // Handshake flags come from state only, so no input-to-output comb path.
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == DONE);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_zlow  <= '0;
      rsp_zhigh <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            alu_a <= req_a;
            alu_b <= req_b;
            if (w_go) begin
              alu_ctrl <= w_ctrl;
              r_cnt    <= w_lat - CNT_W'(1);
              r_state  <= EXEC;
            end else begin
              alu_ctrl  <= '0;
              rsp_zlow  <= '0;
              rsp_zhigh <= '0;
              rsp_err   <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            rsp_zlow  <= alu_zlow;
            rsp_zhigh <= alu_zhigh;
            rsp_err   <= 1'b0;
            alu_ctrl  <= '0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// Testbench for alu_op_sequencer: behavioural ALU plus reference model,
// directed cases followed by randomized operations with backpressure.
module tb_alu_op_sequencer;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_zlow, alu_zhigh;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_zlow, rsp_zhigh;
  logic        rsp_err;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clock = ~clock;

  alu_op_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_zlow  (alu_zlow),
    .alu_zhigh (alu_zhigh),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_zlow  (rsp_zlow),
    .rsp_zhigh (rsp_zhigh),
    .rsp_err   (rsp_err)
  );

  // Reference ALU arithmetic: returns {zhigh, zlow}.
  function automatic logic [63:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] d;
    logic [63:0] r;
    r = 64'd0;
    d = {a, a};
    case (op)
      4'd0:  r = {32'd0, a} + {32'd0, b};
      4'd1:  r = {31'd0, (a < b), a - b};
      4'd2:  r = {32'd0, a} * {32'd0, b};
      4'd3:  r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      4'd4:  r = {32'd0, a >> b[4:0]};
      4'd5:  r = {32'd0, a << b[4:0]};
      4'd6:  begin d = d >> b[4:0]; r = {32'd0, d[31:0]}; end
      4'd7:  begin d = d << b[4:0]; r = {32'd0, d[63:32]}; end
      4'd8:  r = {32'd0, a & b};
      4'd9:  r = {32'd0, a | b};
      4'd10: r = {32'd0, -a};
      4'd11: r = {32'd0, ~a};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Behavioural ALU: garbage unless the control word is exactly one-hot.
  logic [63:0] aluOut;
  always_comb begin
    aluOut = {2{32'hDEAD_BEEF}};
    for (int i = 0; i < 12; i++) begin
      if (alu_ctrl == (12'd1 << i)) aluOut = refAlu(4'(i), alu_a, alu_b);
    end
  end
  assign alu_zlow  = aluOut[31:0];
  assign alu_zhigh = aluOut[63:32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete transaction: request, hold window, response, bp cycles, handshake.
  task automatic doOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int bp);
    logic        err;
    int          lat;
    logic [63:0] exp;
    err = (op > 4'd11);
`ifdef ALU_SEQ_DIV0_TRAP_EN
    if (op == 4'd3 && b == 32'd0) err = 1'b1;
`endif
    lat = (op == 4'd2) ? MUL_LAT : (op == 4'd3) ? DIV_LAT : 1;
    exp = err ? 64'd0 : refAlu(op, a, b);

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);

    if (!err) begin
      for (int i = 0; i < lat; i++) begin
        check("ctrl_exec", 64'(alu_ctrl), 64'd1 << op);
        check("rsp_valid_exec", 64'(rsp_valid), 64'd0);
        check("req_ready_exec", 64'(req_ready), 64'd0);
        check("alu_ab_exec", {alu_a, alu_b}, {a, b});
        @(posedge clock); #1;
      end
    end

    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("ctrl_done", 64'(alu_ctrl), 64'd0);
    check("rsp_z", {rsp_zhigh, rsp_zlow}, exp);
    check("rsp_err", 64'(rsp_err), 64'(err));
    check("alu_ab_hold", {alu_a, alu_b}, {a, b});

    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
      @(posedge clock); #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_z", {rsp_zhigh, rsp_zlow}, exp);
      check("bp_err", 64'(rsp_err), 64'(err));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", 64'(rsp_valid), 64'd0);
    check("post_hs_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    clear_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp", {31'd0, rsp_err, rsp_zhigh, rsp_zlow}, 96'd0);
    check("rst_alu", {20'd0, alu_ctrl, alu_a, alu_b}, 108'd0);
    @(negedge clock); clear_n = 1'b1;
    @(posedge clock); #1;

    doOp(4'd0, 32'd5, 32'd7, 0);
    doOp(4'd2, 32'h0001_0000, 32'h0001_0000, 0);
    doOp(4'd3, 32'd100, 32'd7, 0);
    doOp(4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 5);
    doOp(4'd13, 32'd9, 32'd9, 1);
    doOp(4'd3, 32'd55, 32'd0, 0);
    doOp(4'd1, 32'd3, 32'd4, 0);

    // Reset in the middle of a DIV.
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'd1000; req_b = 32'd3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("mid_ctrl", 64'(alu_ctrl), 64'h8);
    clear_n = 1'b0;
    #1;
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_alu", {20'd0, alu_ctrl, alu_a, alu_b}, 108'd0);
    check("arst_rsp", {31'd0, rsp_err, rsp_zhigh, rsp_zlow}, 96'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        @(negedge clock); clear_n = 1'b1;
      end
      @(posedge clock); #1;
      check("arst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    doOp(4'd0, 32'hFFFF_FFFF, 32'd2, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      doOp(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
